// File: rtl/key_pkg.sv
// key_pkg: shared types and 50 MHz default timing for the key debouncer.
package key_pkg;
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} key_state_t;
    localparam int KEY_SYNC_STAGES = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REPEAT_DELAY_CYCLES = 25000000;
    localparam int DEF_REPEAT_PERIOD_CYCLES = 5000000;
endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: synchroniser, debounce FSM and stability counter for one active-low key.
// Auto-repeat of key_press while held is built only when KEY_REPEAT_EN is defined.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
    input  logic clk_50,
    input  logic rst,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    logic [KEY_SYNC_STAGES-1:0] sync;
    logic [CW-1:0] cnt;
    key_state_t state;
    logic s;
    logic rep_fire;
    assign s = ~sync[KEY_SYNC_STAGES-1];
`ifdef KEY_REPEAT_EN
    localparam int RMAX = REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES ? REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int RCW = $clog2(RMAX) + 1;
    localparam logic [RCW-1:0] RD_MAX = RCW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RCW-1:0] RP_MAX = RCW'(REPEAT_PERIOD_CYCLES - 1);
    logic [RCW-1:0] rc;
    logic rep_phase;
    assign rep_fire = state == PRESSED && s && rc == (rep_phase ? RP_MAX : RD_MAX);
    // rc is held at zero outside PRESSED, so every entry into PRESSED restarts the delay
    always_ff @(posedge clk_50) begin
        if (rst || state != PRESSED) begin
            rc <= '0;
            rep_phase <= 1'b0;
        end else if (rep_fire) begin
            rc <= '0;
            rep_phase <= 1'b1;
        end else begin
            rc <= rc + 1'b1;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif
    always_ff @(posedge clk_50) begin
        if (rst) begin
            sync <= '1;
            state <= IDLE;
            cnt <= '0;
            key_level <= 1'b0;
            key_press <= 1'b0;
            key_release <= 1'b0;
        end else begin
            sync <= {sync[KEY_SYNC_STAGES-2:0], key_n};
            key_press <= 1'b0;
            key_release <= 1'b0;
            case (state)
                IDLE: if (s) begin
                    state <= PRESS_WAIT;
                    cnt <= '0;
                end
                PRESS_WAIT: if (!s) begin
                    state <= IDLE;
                end else if (cnt == CNT_MAX) begin
                    state <= PRESSED;
                    key_press <= 1'b1;
                    key_level <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                PRESSED: if (!s) begin
                    state <= RELEASE_WAIT;
                    cnt <= '0;
                end else if (rep_fire) begin
                    key_press <= 1'b1;
                end
                RELEASE_WAIT: if (s) begin
                    state <= PRESSED;
                end else if (cnt == CNT_MAX) begin
                    state <= IDLE;
                    key_release <= 1'b1;
                    key_level <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/key_debounce_scan.sv
// key_debounce_scan: NUM_KEYS debounced active-low keys with press/release pulses and a press-event encoder.
// Define KEY_REPEAT_EN to add auto-repeat of key_press (and key_valid) while a key is held.
module key_debounce_scan
    import key_pkg::*;
#(
    parameter int NUM_KEYS = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES,
    localparam int CODE_W = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk_50,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                key_valid,
    output logic [CODE_W-1:0]   key_code
);
    logic [CODE_W-1:0] low_idx;
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
            .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES)
        ) u_ch (
            .clk_50(clk_50),
            .rst(rst),
            .key_n(key_n[i]),
            .key_level(key_level[i]),
            .key_press(key_press[i]),
            .key_release(key_release[i])
        );
    end
    // Scan downwards so the lowest pressed index wins
    always_comb begin
        low_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) if (key_press[i]) low_idx = CODE_W'(i);
    end
    always_ff @(posedge clk_50) begin
        if (rst) begin
            key_valid <= 1'b0;
            key_code <= '0;
        end else begin
            key_valid <= |key_press;
            if (|key_press) key_code <= low_idx;
        end
    end
endmodule
